// File: rtl/dclock_pkg.sv
// rtl/dclock_pkg.sv - mode encodings shared by the mode controller, alarm setter and selector
package dclock_pkg;

    typedef enum logic [1:0] {
        MODE1_TIME  = 2'd0,
        MODE1_DATE  = 2'd1,
        MODE1_TIMER = 2'd2,
        MODE1_ALARM = 2'd3
    } mode1_e;

    typedef enum logic [1:0] {
        MODE2_NORMAL     = 2'd0,
        MODE2_ALARM_HOUR = 2'd1,
        MODE2_ALARM_MIN  = 2'd2
    } mode2_e;

    function automatic mode1_e next_mode1(input mode1_e m);
        case (m)
            MODE1_TIME:  return MODE1_DATE;
            MODE1_DATE:  return MODE1_TIMER;
            MODE1_TIMER: return MODE1_ALARM;
            default:     return MODE1_TIME;
        endcase
    endfunction

    // Value 3 is never produced; anything unexpected falls back to NORMAL.
    function automatic mode2_e next_mode2(input mode2_e m);
        case (m)
            MODE2_NORMAL:     return MODE2_ALARM_HOUR;
            MODE2_ALARM_HOUR: return MODE2_ALARM_MIN;
            default:          return MODE2_NORMAL;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - per-button debouncer with a registered one-cycle press strobe
module btn_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          level_q, level_d;
    logic          prev_q, prev_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // A sample equal to the current level restarts the run of differing samples.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        prev_d  = level_q;
        press_d = level_q & ~prev_q;
        if (raw != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = raw;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            prev_q  <= prev_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/dclock_mode_ctrl.sv
// rtl/dclock_mode_ctrl.sv - button-driven mode sequencer with increment auto-repeat and idle time-out
module dclock_mode_ctrl
    import dclock_pkg::*;
#(
    parameter int DEB_CYCLES   = 4,
    parameter int REPEAT_DELAY = 2,
    parameter int TIMEOUT      = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_set,
    input  logic       btn_inc,
    input  logic       alarm,
    output logic [1:0] mode1,
    output logic [1:0] mode2,
    output logic       increase,
    output logic       set
);

    localparam int RW = $clog2(REPEAT_DELAY + 2);
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam logic [RW-1:0] RPT_SAT  = RW'(REPEAT_DELAY);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);

    logic mode_press, set_press, inc_press, inc_level;
    logic mode_level_unused, set_level_unused;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk(clk), .reset(reset), .raw(btn_mode), .level(mode_level_unused), .press(mode_press)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_set (
        .clk(clk), .reset(reset), .raw(btn_set), .level(set_level_unused), .press(set_press)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
        .clk(clk), .reset(reset), .raw(btn_inc), .level(inc_level), .press(inc_press)
    );

    mode1_e        mode1_q, mode1_d;
    mode2_e        mode2_q, mode2_d;
    logic          increase_q, increase_d;
    logic          set_q, set_d;
    logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          rpt_fire;
    logic          accepted;

    // Repeat fires on the strobe that brings the held-tick count to REPEAT_DELAY or beyond.
    assign rpt_fire = tick_1hz && inc_level && ((int'(rpt_cnt_q) + 1) >= REPEAT_DELAY);

    always_comb begin
        mode1_d    = mode1_q;
        mode2_d    = mode2_q;
        increase_d = 1'b0;
        set_d      = 1'b0;
        accepted   = 1'b1;
        rpt_cnt_d  = rpt_cnt_q;
        idle_d     = idle_q;

        if (set_press && alarm) begin
            set_d = 1'b1;
        end else if (mode_press) begin
            mode1_d = next_mode1(mode1_q);
            mode2_d = MODE2_NORMAL;
        end else if (set_press) begin
            if (mode1_q == MODE1_ALARM) begin
                mode2_d = next_mode2(mode2_q);
            end else begin
                set_d = 1'b1;
            end
        end else if (inc_press || rpt_fire) begin
            increase_d = 1'b1;
        end else begin
            accepted = 1'b0;
        end

        if (!inc_level) begin
            rpt_cnt_d = '0;
        end else if (tick_1hz && rpt_cnt_q != RPT_SAT) begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
        end

        // A press in the same cycle wins over the forced return.
        if (accepted) begin
            idle_d = '0;
        end else begin
            if (tick_1hz && idle_q != IDLE_MAX) begin
                idle_d = idle_q + 1'b1;
            end
            if (idle_q == IDLE_MAX && (mode1_q != MODE1_TIME || mode2_q != MODE2_NORMAL)) begin
                mode1_d = MODE1_TIME;
                mode2_d = MODE2_NORMAL;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode1_q    <= MODE1_TIME;
            mode2_q    <= MODE2_NORMAL;
            increase_q <= 1'b0;
            set_q      <= 1'b0;
            rpt_cnt_q  <= '0;
            idle_q     <= '0;
        end else begin
            mode1_q    <= mode1_d;
            mode2_q    <= mode2_d;
            increase_q <= increase_d;
            set_q      <= set_d;
            rpt_cnt_q  <= rpt_cnt_d;
            idle_q     <= idle_d;
        end
    end

    assign mode1    = mode1_q;
    assign mode2    = mode2_q;
    assign increase = increase_q;
    assign set      = set_q;

endmodule

// File: tb/tb_dclock_mode_ctrl.sv
// tb/tb_dclock_mode_ctrl.sv - self-checking bench for dclock_mode_ctrl
module tb_dclock_mode_ctrl;

    localparam int DEB = 4;
    localparam int RD  = 2;
    localparam int TO  = 30;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_set = 1'b0;
    logic       btn_inc = 1'b0;
    logic       alarm = 1'b0;
    logic [1:0] mode1, mode2;
    logic       increase, set;

    int vectors = 0;
    int miscompares = 0;
    int inc_seen = 0;
    int set_seen = 0;

    always #5 clk = ~clk;

    dclock_mode_ctrl #(.DEB_CYCLES(DEB), .REPEAT_DELAY(RD), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
        .btn_mode(btn_mode), .btn_set(btn_set), .btn_inc(btn_inc), .alarm(alarm),
        .mode1(mode1), .mode2(mode2), .increase(increase), .set(set)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural reference: per-button run lengths, absolute due cycles for presses.
    int   m_run[3], m_due[3];
    bit   m_lvl[3];
    int   m_cyc = 0, m_held = 0, m_idle = 0, m_m1 = 0, m_m2 = 0;
    bit   e_inc = 0, e_set = 0;

    task automatic model_step(input logic [2:0] raw, input logic tk, input logic al);
        bit pm, ps, pi, rep, acc;
        m_cyc++;
        pm  = (m_due[0] == m_cyc);
        ps  = (m_due[1] == m_cyc);
        pi  = (m_due[2] == m_cyc);
        rep = tk && m_lvl[2] && (m_held + 1 >= RD);
        acc = 1;
        e_inc = 0;
        e_set = 0;
        if (ps && al) e_set = 1;
        else if (pm) begin m_m1 = (m_m1 + 1) % 4; m_m2 = 0; end
        else if (ps) begin
            if (m_m1 == 3) m_m2 = (m_m2 + 1) % 3;
            else e_set = 1;
        end
        else if (pi || rep) e_inc = 1;
        else acc = 0;
        if (!acc && m_idle == TO && (m_m1 != 0 || m_m2 != 0)) begin
            m_m1 = 0;
            m_m2 = 0;
        end
        if (acc) m_idle = 0;
        else if (tk && m_idle < TO) m_idle++;
        m_held = m_lvl[2] ? m_held + int'(tk) : 0;
        for (int b = 0; b < 3; b++) begin
            if (raw[b] != m_lvl[b]) begin
                m_run[b]++;
                if (m_run[b] == DEB) begin
                    m_lvl[b] = raw[b];
                    m_run[b] = 0;
                    if (m_lvl[b]) m_due[b] = m_cyc + 2;
                end
            end else begin
                m_run[b] = 0;
            end
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 3; b++) begin
                m_run[b] = 0;
                m_due[b] = -1;
                m_lvl[b] = 0;
            end
            m_held = 0; m_idle = 0; m_m1 = 0; m_m2 = 0; e_inc = 0; e_set = 0;
        end else begin
            model_step({btn_inc, btn_set, btn_mode}, tick_1hz, alarm);
        end
        #1;
        check("model", {26'd0, mode1, mode2, increase, set},
              32'(m_m1 * 16 + m_m2 * 4 + int'(e_inc) * 2 + int'(e_set)));
    end

    always @(negedge clk) begin
        if (increase === 1'b1) inc_seen++;
        if (set === 1'b1) set_seen++;
    end

    typedef struct {
        logic [2:0] btns;
        logic       al;
        int         ticks;
        int         e_m1;
        int         e_m2;
        int         e_incs;
        int         e_sets;
    } vec_t;

    vec_t tbl[16];

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_tick();
        @(negedge clk) tick_1hz = 1'b1;
        @(negedge clk) tick_1hz = 1'b0;
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        @(negedge clk);
        inc_seen = 0;
        set_seen = 0;
        {btn_mode, btn_set, btn_inc} = v.btns;
        alarm = v.al;
        cycles(8);
        for (int t = 0; t < v.ticks; t++) begin
            tick_1hz = 1'b1;
            @(negedge clk) tick_1hz = 1'b0;
            cycles(2);
        end
        {btn_mode, btn_set, btn_inc} = 3'b000;
        cycles(9);
        pulse_tick();
        pulse_tick();
        cycles(2);
        alarm = 1'b0;
        check($sformatf("vec%0d_mode1", idx), mode1, v.e_m1);
        check($sformatf("vec%0d_mode2", idx), mode2, v.e_m2);
        check($sformatf("vec%0d_incs", idx), inc_seen, v.e_incs);
        check($sformatf("vec%0d_sets", idx), set_seen, v.e_sets);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit pat[6];
        logic [1:0] prev;
        int changes, at;
        int hold[3];

        tbl[0]  = '{3'b100, 1'b0, 0, 1, 0, 0, 0};
        tbl[1]  = '{3'b100, 1'b0, 0, 2, 0, 0, 0};
        tbl[2]  = '{3'b010, 1'b0, 0, 2, 0, 0, 1};
        tbl[3]  = '{3'b001, 1'b0, 0, 2, 0, 1, 0};
        tbl[4]  = '{3'b100, 1'b0, 0, 3, 0, 0, 0};
        tbl[5]  = '{3'b010, 1'b0, 0, 3, 1, 0, 0};
        tbl[6]  = '{3'b010, 1'b0, 0, 3, 2, 0, 0};
        tbl[7]  = '{3'b100, 1'b0, 0, 0, 0, 0, 0};
        tbl[8]  = '{3'b100, 1'b0, 0, 1, 0, 0, 0};
        tbl[9]  = '{3'b100, 1'b0, 0, 2, 0, 0, 0};
        tbl[10] = '{3'b100, 1'b0, 0, 3, 0, 0, 0};
        tbl[11] = '{3'b110, 1'b1, 0, 3, 0, 0, 1};
        tbl[12] = '{3'b010, 1'b1, 0, 3, 0, 0, 1};
        tbl[13] = '{3'b001, 1'b0, 5, 3, 0, 5, 0};
        tbl[14] = '{3'b011, 1'b0, 0, 3, 1, 0, 0};
        tbl[15] = '{3'b111, 1'b0, 0, 0, 0, 0, 0};

        cycles(2);
        check("rst_mode1", mode1, 0);
        check("rst_mode2", mode2, 0);
        check("rst_increase", increase, 0);
        check("rst_set", set, 0);
        reset = 1'b0;
        cycles(2);

        for (int i = 0; i < 16; i++) apply_vec(i, tbl[i]);

        // Latency of a clean press: change lands DEB+1 edges after first high sample.
        @(negedge clk) btn_mode = 1'b1;
        repeat (DEB + 1) @(posedge clk);
        #1 check("lat_before", mode1, 0);
        @(posedge clk);
        #1 check("lat_after", mode1, 1);
        @(negedge clk) btn_mode = 1'b0;
        cycles(8);

        // Bounce: one change, five edges after the last rise (element 2).
        pat = '{1, 0, 1, 1, 1, 1};
        prev = mode1;
        changes = 0;
        at = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk) btn_mode = (i < 6) ? pat[i] : 1'b1;
            @(posedge clk);
            #1;
            if (mode1 !== prev) begin
                changes++;
                at = i;
                prev = mode1;
            end
        end
        check("bounce_changes", changes, 1);
        check("bounce_edge", at, 2 + DEB + 1);
        check("bounce_mode1", mode1, 2);
        @(negedge clk) btn_mode = 1'b0;
        cycles(8);

        // Reset while a button is held: it must be re-qualified, then give one press.
        @(negedge clk) btn_mode = 1'b1;
        cycles(2);
        reset = 1'b1;
        cycles(2);
        check("midrst_mode1", mode1, 0);
        reset = 1'b0;
        repeat (DEB + 1) @(posedge clk);
        #1 check("midrst_before", mode1, 0);
        @(posedge clk);
        #1 check("midrst_press", mode1, 1);
        cycles(12);
        check("midrst_once", mode1, 1);
        btn_mode = 1'b0;
        cycles(8);

        // Idle time-out from DATE.
        repeat (TO - 1) pulse_tick();
        check("to_29", mode1, 1);
        pulse_tick();
        @(posedge clk);
        #1 check("to_30", mode1, 0);

        // A press near the limit restarts the count.
        @(negedge clk) btn_mode = 1'b1;
        cycles(8);
        btn_mode = 1'b0;
        cycles(8);
        repeat (TO - 2) pulse_tick();
        btn_inc = 1'b1;
        cycles(8);
        btn_inc = 1'b0;
        cycles(8);
        repeat (TO - 1) pulse_tick();
        check("to_restart_29", mode1, 1);
        pulse_tick();
        @(posedge clk);
        #1 check("to_restart_30", mode1, 0);

        // Random buttons with glitches, alarm and ticks; the reference model checks every edge.
        for (int b = 0; b < 3; b++) hold[b] = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int b = 0; b < 3; b++) begin
                if (hold[b] == 0) begin
                    logic v;
                    v = ($urandom_range(0, 3) == 0);
                    hold[b] = $urandom_range(1, 12);
                    case (b)
                        0: btn_mode = v;
                        1: btn_set = v;
                        default: btn_inc = v;
                    endcase
                end else begin
                    hold[b]--;
                end
            end
            if ($urandom_range(0, 49) == 0) alarm = ~alarm;
            tick_1hz = ($urandom_range(0, 5) == 0);
        end
        @(negedge clk);
        {btn_mode, btn_set, btn_inc, tick_1hz, alarm} = 5'b0;
        cycles(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
